mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one 64-bit memory port between instruction fetch and the data access port of the RV64 core.
- Serialises requests, holds the memory request stable until acknowledged, and returns the read data with a one-cycle ready pulse.
- Drives the core stall signal and sits between the CPU top level and the unified memory model.
- Includes round-robin fairness and a bus timeout.

Parameters:
- IF_RD_CTRL, 3'b011: rd_ctrl code driven on the memory port for instruction fetch.
- TIMEOUT, 16: cycles to wait for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  64  fetch address.
- if_rdata  out  32  fetched instruction.
- if_ready  out  1  one-cycle fetch-done pulse.
- dm_rd_ctrl  in  3  data read control; 0 means no read.
- dm_wr_ctrl  in  3  data write control; 0 means no write.
- dm_addr  in  64  data address.
- dm_din  in  64  store data.
- dm_dout  out  64  load data.
- dm_ready  out  1  one-cycle data-done pulse.
- cpu_stall  out  1  core must hold PC and pipeline.
- mem_req  out  1  memory request valid.
- mem_rd_ctrl  out  3  read control to memory.
- mem_wr_ctrl  out  3  write control to memory.
- mem_addr  out  64  memory address.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Request definitions: dm_req = (dm_rd_ctrl != 0) | (dm_wr_ctrl != 0). If both controls are nonzero, the access is a write: mem_rd_ctrl = 0.
- Reset (rst low, asynchronous): state IDLE; mem_req, mem_rd_ctrl, mem_wr_ctrl, mem_addr, mem_wdata = 0; if_rdata, dm_dout = 0; if_ready, dm_ready = 0; bus_err = 0; last_grant = IF; timeout counter = 0. Reset mid-transaction drops mem_req immediately. An outstanding memory ack after reset is ignored.
- FSM states:
  - IDLE: a request is eligible only if its ready output is low this cycle, which prevents double service. If only one request is eligible, grant it. If both are eligible, grant data when last_grant == IF, otherwise grant fetch. On grant, register the address, controls and wdata into the mem_* outputs, set mem_req = 1, update last_grant and go to BUSY. Fetch drives mem_rd_ctrl = IF_RD_CTRL, mem_wr_ctrl = 0 and mem_wdata = 0.
  - BUSY: mem_* outputs are held stable. On mem_ack: capture mem_rdata (fetch: if_rdata <= mem_rdata[31:0]; data: dm_dout <= mem_rdata, and writes also update dm_dout), set the matching ready for exactly one cycle, clear mem_req and go to IDLE. An ack arriving in the same cycle as a timeout expiry takes precedence over the timeout.
  - Timeout: the counter increments each BUSY cycle without an ack. When TIMEOUT != 0 and the count reaches TIMEOUT, clear mem_req, set bus_err (sticky until reset), return zero data with the ready pulse, and go to IDLE.
- Latency: request seen in cycle 0 → mem_req high in cycle 1. An ack in cycle k ≥ 1 gives ready in cycle k+1. Back-to-back: the next grant is decided in the ready cycle, and the next mem_req rises in the following cycle. Minimum 2 cycles per access.
- cpu_stall is combinational: (if_req & ~if_ready) | (dm_req & ~dm_ready).
- mem_ack seen in IDLE is ignored. Requesters must hold their inputs stable until ready; a change before ready is undefined.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x1000; ack in cycle 3 with mem_rdata = 0x0000_0000_0051_3023 → mem_rd_ctrl = IF_RD_CTRL, mem_addr = 0x1000, if_rdata = 0x00513023, if_ready pulses in cycle 4, cpu_stall low in cycle 4.
- Store: dm_wr_ctrl = 3'b100, dm_addr = 0x2008, dm_din = 0xDEAD_BEEF_0000_0001, ack after 1 cycle → mem_wr_ctrl = 3'b100, mem_rd_ctrl = 0, mem_wdata matches dm_din, dm_ready is a single pulse.
- Contention: if_req and a load both pending from reset, ack after 1 cycle each → grant order is data, fetch, data, fetch. No request is serviced twice, and the ready pulses alternate.
- Timeout: TIMEOUT = 4, no ack → mem_req drops after 4 BUSY cycles, if_ready pulses with if_rdata = 0, bus_err = 1 and stays high until reset.
- Reset mid-BUSY: assert rst low while mem_req = 1 → mem_req and all outputs are 0 without waiting for a clock edge. A late mem_ack after release produces no ready pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and data access.
// Round-robin on contention, with a bus timeout that sets a sticky error flag.
module mem_arbiter #(
  parameter logic [2:0]  IF_RD_CTRL = 3'b011,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic [2:0]  dm_rd_ctrl,
  input  logic [2:0]  dm_wr_ctrl,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_din,
  output logic [63:0] dm_dout,
  output logic        dm_ready,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic [2:0]  mem_rd_ctrl,
  output logic [2:0]  mem_wr_ctrl,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_dm;
  logic             r_cur_dm;
  logic [CNT_W-1:0] r_cnt;

  logic w_dm_req;
  logic w_dm_is_wr;
  logic w_if_elig;
  logic w_dm_elig;
  logic w_grant_if;
  logic w_grant_dm;
  logic w_ack_done;
  logic w_tout;

  assign w_dm_req   = (dm_rd_ctrl != 3'd0) || (dm_wr_ctrl != 3'd0);
  assign w_dm_is_wr = (dm_wr_ctrl != 3'd0);
  // A requester whose ready is high this cycle is still holding the request it just got served
  assign w_if_elig  = if_req & ~if_ready;
  assign w_dm_elig  = w_dm_req & ~dm_ready;
  assign cpu_stall  = (if_req & ~if_ready) | (w_dm_req & ~dm_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_grant_if = 1'b0;
    w_grant_dm = 1'b0;
    w_ack_done = 1'b0;
    w_tout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_if_elig && w_dm_elig) begin
          w_grant_dm = ~r_last_dm;
          w_grant_if = r_last_dm;
        end else begin
          w_grant_if = w_if_elig;
          w_grant_dm = w_dm_elig;
        end
        if (w_if_elig || w_dm_elig) w_next = S_BUSY;
      end
      S_BUSY: begin
        // An ack in the expiry cycle wins over the timeout
        if (mem_ack) begin
          w_ack_done = 1'b1;
          w_next     = S_IDLE;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_tout = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req     <= 1'b0;
      mem_rd_ctrl <= 3'd0;
      mem_wr_ctrl <= 3'd0;
      mem_addr    <= 64'd0;
      mem_wdata   <= 64'd0;
      if_rdata    <= 32'd0;
      dm_dout     <= 64'd0;
      if_ready    <= 1'b0;
      dm_ready    <= 1'b0;
      bus_err     <= 1'b0;
      r_last_dm   <= 1'b0;
      r_cur_dm    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if (w_grant_if) begin
        mem_req     <= 1'b1;
        mem_rd_ctrl <= IF_RD_CTRL;
        mem_wr_ctrl <= 3'd0;
        mem_addr    <= if_addr;
        mem_wdata   <= 64'd0;
        r_last_dm   <= 1'b0;
        r_cur_dm    <= 1'b0;
        r_cnt       <= '0;
      end else if (w_grant_dm) begin
        mem_req     <= 1'b1;
        mem_rd_ctrl <= w_dm_is_wr ? 3'd0 : dm_rd_ctrl;
        mem_wr_ctrl <= dm_wr_ctrl;
        mem_addr    <= dm_addr;
        mem_wdata   <= dm_din;
        r_last_dm   <= 1'b1;
        r_cur_dm    <= 1'b1;
        r_cnt       <= '0;
      end else if (w_ack_done || w_tout) begin
        mem_req <= 1'b0;
        if (r_cur_dm) begin
          dm_ready <= 1'b1;
          dm_dout  <= w_ack_done ? mem_rdata : 64'd0;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= w_ack_done ? mem_rdata[31:0] : 32'd0;
        end
        if (w_tout) bus_err <= 1'b1;
      end else if ((r_state == S_BUSY) && (TIMEOUT != 0)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed latency/timeout/reset cases, then randomized traffic
// against a transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam logic [2:0] IFC = 3'b011;
  localparam int         TO  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic [2:0]  dm_rd_ctrl;
  logic [2:0]  dm_wr_ctrl;
  logic [63:0] dm_addr;
  logic [63:0] dm_din;
  logic [63:0] dm_dout;
  logic        dm_ready;
  logic        cpu_stall;
  logic        mem_req;
  logic [2:0]  mem_rd_ctrl;
  logic [2:0]  mem_wr_ctrl;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.IF_RD_CTRL(IFC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_dout(dm_dout), .dm_ready(dm_ready), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_rd_ctrl(mem_rd_ctrl), .mem_wr_ctrl(mem_wr_ctrl),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    dm_rd_ctrl = '0; dm_wr_ctrl = '0; dm_addr = '0; dm_din = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = {$urandom, $urandom} & ~64'h3;
  endtask

  task automatic new_dm(input bit rd_only);
    int kind;
    kind = rd_only ? 0 : $urandom_range(0, 2);
    dm_addr = {$urandom, $urandom} & ~64'h7;
    dm_din  = {$urandom, $urandom};
    case (kind)
      0:       begin dm_rd_ctrl = 3'($urandom_range(1, 7)); dm_wr_ctrl = 3'd0; end
      1:       begin dm_rd_ctrl = 3'd0; dm_wr_ctrl = 3'($urandom_range(1, 7)); end
      default: begin dm_rd_ctrl = 3'($urandom_range(1, 7)); dm_wr_ctrl = 3'($urandom_range(1, 7)); end
    endcase
  endtask

  // Reference model: one transaction at a time, round-robin when both requesters wait,
  // a requester being acknowledged this cycle is not a new request.
  task automatic run_model(input int ncyc, input bit contend, output logic [3:0] first4);
    bit          m_busy = 0, m_owner_dm = 0, m_last_dm = 0;
    int          m_cnt = 0, ack_at = 0, ngr = 0, if_gap = 0, dm_gap = 0, r;
    logic        m_mem_req = 0, m_if_rdy = 0, m_dm_rdy = 0, n_if_rdy, n_dm_rdy;
    logic [2:0]  m_rd = 0, m_wr = 0;
    logic [63:0] m_addr = 0, m_wdata = 0, m_dm_data = 0;
    logic [31:0] m_if_data = 0;
    bit          pi, pd, gdm, dm_any;
    first4 = '0;
    for (int c = 0; c < ncyc; c++) begin
      chk("rnd_mem_req",  mem_req,  m_mem_req);
      chk("rnd_mem_addr", mem_addr, m_addr);
      chk("rnd_mem_rd",   mem_rd_ctrl, m_rd);
      chk("rnd_mem_wr",   mem_wr_ctrl, m_wr);
      chk("rnd_mem_wdata", mem_wdata, m_wdata);
      chk("rnd_if_ready", if_ready, m_if_rdy);
      chk("rnd_dm_ready", dm_ready, m_dm_rdy);
      chk("rnd_if_rdata", if_rdata, m_if_data);
      chk("rnd_dm_dout",  dm_dout,  m_dm_data);
      chk("rnd_bus_err",  bus_err,  1'b0);

      // requesters: on ready, renew at once, hold one more cycle, or drop
      if (if_gap < 0) begin
        if (m_if_rdy) begin
          r = contend ? 0 : $urandom_range(0, 2);
          if (r == 0) new_if();
          else begin if_gap = $urandom_range(1, 2); if (r == 2) if_req = 1'b0; end
        end
      end else if (if_gap == 0) begin new_if(); if_gap = -1; end
      else begin if_req = 1'b0; if_gap--; end

      if (dm_gap < 0) begin
        if (m_dm_rdy) begin
          r = contend ? 0 : $urandom_range(0, 2);
          if (r == 0) new_dm(contend);
          else begin dm_gap = $urandom_range(1, 2); if (r == 2) begin dm_rd_ctrl = 0; dm_wr_ctrl = 0; end end
        end
      end else if (dm_gap == 0) begin new_dm(contend); dm_gap = -1; end
      else begin dm_rd_ctrl = 0; dm_wr_ctrl = 0; dm_gap--; end

      mem_ack = 1'b0;
      if (m_busy && (m_cnt == ack_at)) begin
        mem_ack   = 1'b1;
        mem_rdata = {$urandom, $urandom};
      end

      #1;
      dm_any = (dm_rd_ctrl != 0) || (dm_wr_ctrl != 0);
      chk("rnd_cpu_stall", cpu_stall, (if_req && !m_if_rdy) || (dm_any && !m_dm_rdy));

      n_if_rdy = 1'b0;
      n_dm_rdy = 1'b0;
      if (m_busy) begin
        if (mem_ack) begin
          m_busy = 0; m_mem_req = 1'b0;
          if (m_owner_dm) begin n_dm_rdy = 1'b1; m_dm_data = mem_rdata; end
          else begin n_if_rdy = 1'b1; m_if_data = mem_rdata[31:0]; end
        end else m_cnt++;
      end else begin
        pi = if_req && !m_if_rdy;
        pd = dm_any && !m_dm_rdy;
        if (pi || pd) begin
          gdm = pd && (!pi || !m_last_dm);
          if (gdm) begin
            m_rd = (dm_wr_ctrl != 0) ? 3'd0 : dm_rd_ctrl;
            m_wr = dm_wr_ctrl; m_addr = dm_addr; m_wdata = dm_din;
          end else begin
            m_rd = IFC; m_wr = 3'd0; m_addr = if_addr; m_wdata = '0;
          end
          m_mem_req = 1'b1; m_busy = 1; m_owner_dm = gdm; m_last_dm = gdm; m_cnt = 0;
          ack_at = contend ? 1 : $urandom_range(0, TO - 1);
          if (ngr < 4) first4[3 - ngr] = gdm;
          ngr++;
        end
      end
      m_if_rdy = n_if_rdy;
      m_dm_rdy = n_dm_rdy;
      tick();
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] order;
    int hi;
    rst = 1'b1;
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_if_ready", if_ready, 1'b0);
    chk("rst_dm_ready", dm_ready, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_cpu_stall", cpu_stall, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();

    // single fetch, ack in cycle 3
    if_req = 1'b1; if_addr = 64'h1000;
    #1 chk("fetch_stall_c0", cpu_stall, 1'b1);
    tick();
    chk("fetch_mem_req", mem_req, 1'b1);
    chk("fetch_rd_ctrl", mem_rd_ctrl, IFC);
    chk("fetch_wr_ctrl", mem_wr_ctrl, 3'd0);
    chk("fetch_addr", mem_addr, 64'h1000);
    tick();
    tick();
    chk("fetch_ready_c3", if_ready, 1'b0);
    mem_ack = 1'b1; mem_rdata = 64'h0000_0000_0051_3023;
    tick();
    mem_ack = 1'b0;
    chk("fetch_ready_c4", if_ready, 1'b1);
    chk("fetch_rdata", if_rdata, 32'h0051_3023);
    chk("fetch_stall_c4", cpu_stall, 1'b0);
    chk("fetch_req_drop", mem_req, 1'b0);
    tick();
    if_req = 1'b0;
    chk("fetch_no_reserve", mem_req, 1'b0);
    chk("fetch_pulse_end", if_ready, 1'b0);

    // store, ack one cycle after mem_req rises
    tick();
    dm_wr_ctrl = 3'b100; dm_addr = 64'h2008; dm_din = 64'hDEAD_BEEF_0000_0001;
    tick();
    chk("store_mem_req", mem_req, 1'b1);
    chk("store_wr_ctrl", mem_wr_ctrl, 3'b100);
    chk("store_rd_ctrl", mem_rd_ctrl, 3'd0);
    chk("store_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0001);
    chk("store_addr", mem_addr, 64'h2008);
    tick();
    mem_ack = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    tick();
    mem_ack = 1'b0;
    chk("store_ready", dm_ready, 1'b1);
    chk("store_dout", dm_dout, 64'h1234_5678_9ABC_DEF0);
    dm_wr_ctrl = 3'd0;
    tick();
    chk("store_pulse_end", dm_ready, 1'b0);

    // timeout with no ack
    if_req = 1'b1; if_addr = 64'h3000;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_req) hi++;
      else if (i > 0) break;
    end
    chk("tout_busy_cycles", hi, 4);
    chk("tout_if_ready", if_ready, 1'b1);
    chk("tout_if_rdata", if_rdata, 32'd0);
    chk("tout_bus_err", bus_err, 1'b1);
    if_req = 1'b0;
    tick();
    chk("tout_pulse_end", if_ready, 1'b0);
    repeat (3) tick();
    chk("tout_err_sticky", bus_err, 1'b1);

    // asynchronous reset while a write is outstanding
    dm_wr_ctrl = 3'b011; dm_addr = 64'h4010; dm_din = 64'hCAFE_F00D_1122_3344;
    tick();
    chk("midrst_req_before", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_mem_addr", mem_addr, 64'd0);
    chk("midrst_mem_wdata", mem_wdata, 64'd0);
    chk("midrst_mem_wr", mem_wr_ctrl, 3'd0);
    chk("midrst_dm_dout", dm_dout, 64'd0);
    chk("midrst_bus_err", bus_err, 1'b0);
    idle_inputs();
    #1 rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_if_ready", if_ready, 1'b0);
    chk("late_ack_dm_ready", dm_ready, 1'b0);
    chk("late_ack_mem_req", mem_req, 1'b0);
    tick();
    chk("late_ack_after", if_ready | dm_ready, 1'b0);

    // contention from reset: data, fetch, data, fetch
    do_reset();
    run_model(40, 1'b1, order);
    chk("contention_order", order, 4'b1010);

    do_reset();
    run_model(2000, 1'b0, order);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
